id_ex_stage_hz: RTL and testbench
=================================

Name: id_ex_stage_hz

Overview:
- Parametrised decode-to-execute pipeline stage for the DLX pipeline.
- Takes one decoded instruction per cycle from the decoder and resolves both source operands, forwarding from EX, MEM and WB.
- Detects load-use hazards and inserts bubbles; resolves ID-stage jumps (target redirect to IF).
- Registers the instruction into the ID/EX pipeline register under a valid/ready handshake with EX, with flush (nullify) support.

Parameters:
- XLEN, 32, datapath width (operands, immediate, PC).
- NREG, 32, architectural register count; RA_W = $clog2(NREG).
- FWD_EN, 1, 1 = forwarding active; 0 = every RAW hazard on a pending writer stalls.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous, active-low reset.
- id_valid  in  1  decoded instruction present in ID.
- id_ready  out  1  ID instruction accepted this cycle; IF/ID may advance.
- id_ctrl  in  ctrl_t  decoded control bundle.
- id_rs1, id_rs2, id_rd  in  RA_W  register addresses.
- id_imm, id_pc  in  XLEN  immediate, instruction PC.
- rf_s1, rf_s2  in  XLEN  raw register-file reads for id_rs1/id_rs2.
- ex_fwd_val  in  XLEN  EX ALU result (instruction currently in the EX register).
- mem_rd, wb_rd  in  RA_W  destination in MEM/WB; 0 = no write.
- mem_val, wb_val  in  XLEN  MEM/WB result.
- mem_is_load  in  1  MEM instruction is a load whose data is not yet in mem_val.
- nullify  in  1  branch taken in EX; kill the ID instruction.
- ex_ready  in  1  EX accepts the registered instruction.
- redirect  out  1  ID-resolved jump taken.
- redirect_pc  out  XLEN  jump target.
- ex_valid  out  1  EX register holds a live instruction.
- ex_ctrl  out  ctrl_t  registered control bundle.
- ex_rd, ex_rs1, ex_rs2  out  RA_W  registered addresses.
- ex_imm, ex_pc, ex_s1, ex_s2  out  XLEN  registered immediate, PC, resolved operands.
- stall_cnt  out  CNT_W  saturating count of load-use stall cycles.

Behaviour:
- Reset: every registered output is 0, ex_ctrl = CTRL_NOP, stall_cnt = 0. The reset value of each combinational output (id_ready, redirect, redirect_pc) is the value of its equation with ex_valid=0.
- Operand resolution, combinational, per source independently:
  - Address 0 always resolves to 0.
  - Otherwise, priority: EX (ex_valid & ex_ctrl.we_reg & !ex_ctrl.ld & ex_rd match) > MEM (mem_rd match & !mem_is_load) > WB (wb_rd match) > rf value.
- Hazard, hz=1 when id_valid and a used source (nonzero address) matches either of:
  - an EX load destination;
  - a MEM load destination (mem_is_load).
  - With FWD_EN=0, any matching pending EX/MEM writer also sets hz.
- Advance condition: adv = ex_ready | !ex_valid.
- id_ready = adv & !hz. nullify forces id_ready=1, and the ID instruction is discarded.
- EX register update on each posedge, in priority order:
  1. Reset.
  2. !adv: hold all fields.
  3. nullify | hz | !id_valid: load bubble (ex_valid=0, ex_ctrl=CTRL_NOP, addresses 0).
  4. Otherwise: load the ID fields and resolved operands; ex_valid=1.
- Latency: 1 cycle ID to EX. A load-use hazard costs exactly 1 bubble; hz clears when the load reaches WB, or when its data appears in mem_val with mem_is_load dropped.
- nullify with ex_ready=0: the EX register holds, and the ID instruction is still dropped.
- Jump redirect:
  - redirect = id_valid & id_ctrl.jump_id & !hz & !nullify & adv.
  - redirect_pc = id_ctrl.pc_add ? id_pc + id_imm : resolved s1. Wrap-around is modulo 2^XLEN.
- stall_cnt increments on every cycle with id_valid & hz & !nullify and saturates at all-ones.

Decomposition:
- Package dlx_pipe_pkg holds:
  - ctrl_t packed struct: we_reg, ld, st, iv_alu, pc_alu, alu_op[4:0], pc_cmd_ex, jump_id, pc_add.
  - CTRL_NOP (all zero).
  - REG_ZERO.
- Sub-module operand_fwd: one source's priority mux and hazard match; instantiated twice (s1, s2).

Test Plan:
- Reset mid-stream: valid add in EX, reset_n=0 for 1 cycle -> ex_valid=0, ex_s1=0, stall_cnt=0 after the edge.
- Double forward: MEM writes r3=0x11, WB writes r3=0x22, ID reads rs1=r3 -> ex_s1=0x11 next cycle.
- Zero register: rs1=r0 while EX writes r0=0x55 -> ex_s1=0.
- Load-use: EX is lw r5, ID is add r6,r5,r1 -> id_ready=0 for 1 cycle, one bubble, stall_cnt=1. The add enters EX 2 cycles later with ex_s1=mem_val.
- Flush under backpressure: nullify=1 with ex_ready=0 -> EX register unchanged, id_ready=1, ID instruction never appears in EX.
- Jump: jump_id, pc_add=1, id_pc=0xFFFFFFFC, id_imm=8 -> redirect=1, redirect_pc=0x00000004. Same instruction with hz=1 -> redirect=0.

Source files
------------

// File: rtl/dlx_pipe_pkg.sv
// Shared types for the DLX pipeline: the decoded control bundle and register constants.
package dlx_pipe_pkg;

  typedef struct packed {
    logic       we_reg;
    logic       ld;
    logic       st;
    logic       iv_alu;
    logic       pc_alu;
    logic [4:0] alu_op;
    logic       pc_cmd_ex;
    logic       jump_id;
    logic       pc_add;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;
  localparam int    REG_ZERO = 0;

endpackage

// File: rtl/operand_fwd.sv
// One source operand: forwarding priority mux (EX > MEM > WB > RF) and load-use/RAW hazard match.
module operand_fwd
  import dlx_pipe_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int RA_W   = 5,
  parameter int FWD_EN = 1
) (
  input  logic [RA_W-1:0] rs_i,
  input  logic [XLEN-1:0] rf_val_i,
  input  logic            ex_valid_i,
  input  logic            ex_we_i,
  input  logic            ex_ld_i,
  input  logic [RA_W-1:0] ex_rd_i,
  input  logic [XLEN-1:0] ex_val_i,
  input  logic [RA_W-1:0] mem_rd_i,
  input  logic [XLEN-1:0] mem_val_i,
  input  logic            mem_is_load_i,
  input  logic [RA_W-1:0] wb_rd_i,
  input  logic [XLEN-1:0] wb_val_i,
  output logic [XLEN-1:0] val_o,
  output logic            hz_o
);

  localparam bit FwdOff = (FWD_EN == 0);

  logic used, ex_hit, ex_wr, ex_ld_hit, mem_hit, mem_wr, wb_hit;

  assign used      = (rs_i != RA_W'(REG_ZERO));
  assign ex_hit    = used & ex_valid_i & (ex_rd_i == rs_i);
  assign ex_wr     = ex_hit & ex_we_i & ~ex_ld_i;
  assign ex_ld_hit = ex_hit & ex_ld_i;
  assign mem_hit   = used & (mem_rd_i == rs_i);
  assign mem_wr    = mem_hit & ~mem_is_load_i;
  assign wb_hit    = used & (wb_rd_i == rs_i);

  // Load data not yet available always stalls; without forwarding every pending writer does.
  assign hz_o = ex_ld_hit | (mem_hit & mem_is_load_i) | (FwdOff & (ex_wr | mem_wr));

  always_comb begin
    val_o = rf_val_i;
    if (!used)       val_o = '0;
    else if (ex_wr)  val_o = ex_val_i;
    else if (mem_wr) val_o = mem_val_i;
    else if (wb_hit) val_o = wb_val_i;
  end

endmodule

// File: rtl/id_ex_stage_hz.sv
// DLX decode-to-execute stage: operand forwarding, load-use bubbles, ID jump redirect, ID/EX register.
module id_ex_stage_hz
  import dlx_pipe_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16,
  localparam int RA_W  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            id_valid,
  output logic            id_ready,
  input  ctrl_t           id_ctrl,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic [XLEN-1:0] id_imm,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] rf_s1,
  input  logic [XLEN-1:0] rf_s2,
  input  logic [XLEN-1:0] ex_fwd_val,
  input  logic [RA_W-1:0] mem_rd,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] mem_val,
  input  logic [XLEN-1:0] wb_val,
  input  logic            mem_is_load,
  input  logic            nullify,
  input  logic            ex_ready,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            ex_valid,
  output ctrl_t           ex_ctrl,
  output logic [RA_W-1:0] ex_rd,
  output logic [RA_W-1:0] ex_rs1,
  output logic [RA_W-1:0] ex_rs2,
  output logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_s1,
  output logic [XLEN-1:0] ex_s2,
  output logic [CNT_W-1:0] stall_cnt
);

  logic            ex_valid_q, ex_valid_d;
  ctrl_t           ex_ctrl_q, ex_ctrl_d;
  logic [RA_W-1:0] ex_rd_q, ex_rd_d, ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
  logic [XLEN-1:0] ex_imm_q, ex_imm_d, ex_pc_q, ex_pc_d;
  logic [XLEN-1:0] ex_s1_q, ex_s1_d, ex_s2_q, ex_s2_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic [XLEN-1:0] s1_res, s2_res;
  logic            hz1, hz2, hz, adv;

  operand_fwd #(.XLEN(XLEN), .RA_W(RA_W), .FWD_EN(FWD_EN)) u_fwd_s1 (
    .rs_i(id_rs1), .rf_val_i(rf_s1),
    .ex_valid_i(ex_valid_q), .ex_we_i(ex_ctrl_q.we_reg), .ex_ld_i(ex_ctrl_q.ld),
    .ex_rd_i(ex_rd_q), .ex_val_i(ex_fwd_val),
    .mem_rd_i(mem_rd), .mem_val_i(mem_val), .mem_is_load_i(mem_is_load),
    .wb_rd_i(wb_rd), .wb_val_i(wb_val),
    .val_o(s1_res), .hz_o(hz1)
  );

  operand_fwd #(.XLEN(XLEN), .RA_W(RA_W), .FWD_EN(FWD_EN)) u_fwd_s2 (
    .rs_i(id_rs2), .rf_val_i(rf_s2),
    .ex_valid_i(ex_valid_q), .ex_we_i(ex_ctrl_q.we_reg), .ex_ld_i(ex_ctrl_q.ld),
    .ex_rd_i(ex_rd_q), .ex_val_i(ex_fwd_val),
    .mem_rd_i(mem_rd), .mem_val_i(mem_val), .mem_is_load_i(mem_is_load),
    .wb_rd_i(wb_rd), .wb_val_i(wb_val),
    .val_o(s2_res), .hz_o(hz2)
  );

  assign hz          = id_valid & (hz1 | hz2);
  assign adv         = ex_ready | ~ex_valid_q;
  assign id_ready    = nullify | (adv & ~hz);
  assign redirect    = id_valid & id_ctrl.jump_id & ~hz & ~nullify & adv;
  assign redirect_pc = id_ctrl.pc_add ? (id_pc + id_imm) : s1_res;

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_ctrl_d  = ex_ctrl_q;
    ex_rd_d    = ex_rd_q;
    ex_rs1_d   = ex_rs1_q;
    ex_rs2_d   = ex_rs2_q;
    ex_imm_d   = ex_imm_q;
    ex_pc_d    = ex_pc_q;
    ex_s1_d    = ex_s1_q;
    ex_s2_d    = ex_s2_q;
    if (adv) begin
      if (nullify | hz | ~id_valid) begin
        ex_valid_d = 1'b0;
        ex_ctrl_d  = CTRL_NOP;
        ex_rd_d    = '0;
        ex_rs1_d   = '0;
        ex_rs2_d   = '0;
        ex_imm_d   = '0;
        ex_pc_d    = '0;
        ex_s1_d    = '0;
        ex_s2_d    = '0;
      end else begin
        ex_valid_d = 1'b1;
        ex_ctrl_d  = id_ctrl;
        ex_rd_d    = id_rd;
        ex_rs1_d   = id_rs1;
        ex_rs2_d   = id_rs2;
        ex_imm_d   = id_imm;
        ex_pc_d    = id_pc;
        ex_s1_d    = s1_res;
        ex_s2_d    = s2_res;
      end
    end
    stall_d = stall_q;
    if (hz && !nullify && stall_q != '1) stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ex_valid_q <= 1'b0;
      ex_ctrl_q  <= CTRL_NOP;
      ex_rd_q    <= '0;
      ex_rs1_q   <= '0;
      ex_rs2_q   <= '0;
      ex_imm_q   <= '0;
      ex_pc_q    <= '0;
      ex_s1_q    <= '0;
      ex_s2_q    <= '0;
      stall_q    <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_ctrl_q  <= ex_ctrl_d;
      ex_rd_q    <= ex_rd_d;
      ex_rs1_q   <= ex_rs1_d;
      ex_rs2_q   <= ex_rs2_d;
      ex_imm_q   <= ex_imm_d;
      ex_pc_q    <= ex_pc_d;
      ex_s1_q    <= ex_s1_d;
      ex_s2_q    <= ex_s2_d;
      stall_q    <= stall_d;
    end
  end

  assign ex_valid  = ex_valid_q;
  assign ex_ctrl   = ex_ctrl_q;
  assign ex_rd     = ex_rd_q;
  assign ex_rs1    = ex_rs1_q;
  assign ex_rs2    = ex_rs2_q;
  assign ex_imm    = ex_imm_q;
  assign ex_pc     = ex_pc_q;
  assign ex_s1     = ex_s1_q;
  assign ex_s2     = ex_s2_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_id_ex_stage_hz.sv
// Directed bench for id_ex_stage_hz: forwarding, load-use bubbles, flush, jump redirect, stall counter.
module tb_id_ex_stage_hz;
  import dlx_pipe_pkg::*;

  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int RA_W  = 5;
  localparam int CNT_W = 4;

  logic            clk = 1'b0;
  logic            reset_n, id_valid, id_ready, mem_is_load, nullify, ex_ready;
  ctrl_t           id_ctrl, ex_ctrl;
  logic [RA_W-1:0] id_rs1, id_rs2, id_rd, mem_rd, wb_rd, ex_rd, ex_rs1, ex_rs2;
  logic [XLEN-1:0] id_imm, id_pc, rf_s1, rf_s2, ex_fwd_val, mem_val, wb_val;
  logic [XLEN-1:0] redirect_pc, ex_imm, ex_pc, ex_s1, ex_s2;
  logic            redirect, ex_valid;
  logic [CNT_W-1:0] stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  id_ex_stage_hz #(.XLEN(XLEN), .NREG(NREG), .FWD_EN(1), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_ready(id_ready),
    .id_ctrl(id_ctrl), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_imm(id_imm), .id_pc(id_pc), .rf_s1(rf_s1), .rf_s2(rf_s2),
    .ex_fwd_val(ex_fwd_val), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .mem_val(mem_val), .wb_val(wb_val), .mem_is_load(mem_is_load),
    .nullify(nullify), .ex_ready(ex_ready), .redirect(redirect),
    .redirect_pc(redirect_pc), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
    .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_imm(ex_imm),
    .ex_pc(ex_pc), .ex_s1(ex_s1), .ex_s2(ex_s2), .stall_cnt(stall_cnt)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic ctrl_t mk_ctrl(input logic we, input logic ld, input logic jmp, input logic pca);
    ctrl_t c;
    c = CTRL_NOP;
    c.we_reg  = we;
    c.ld      = ld;
    c.jump_id = jmp;
    c.pc_add  = pca;
    c.alu_op  = 5'd1;
    return c;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_ctrl = CTRL_NOP; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_imm = 0; id_pc = 0; rf_s1 = 0; rf_s2 = 0; ex_fwd_val = 0;
    mem_rd = 0; wb_rd = 0; mem_val = 0; wb_val = 0; mem_is_load = 0;
    nullify = 0; ex_ready = 1;
  endtask

  task automatic issue(input ctrl_t c, input logic [RA_W-1:0] rd, input logic [RA_W-1:0] s1,
                       input logic [RA_W-1:0] s2, input logic [XLEN-1:0] v1, input logic [XLEN-1:0] v2);
    id_valid = 1; id_ctrl = c; id_rd = rd; id_rs1 = s1; id_rs2 = s2; rf_s1 = v1; rf_s2 = v2;
  endtask

  initial begin
    idle_inputs();
    reset_n = 0;
    step(); step();
    settle();
    check("rst_ex_valid", ex_valid, 0);
    check("rst_ex_ctrl", 64'(ex_ctrl), 0);
    check("rst_ex_s1", ex_s1, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_id_ready", id_ready, 1);
    check("rst_redirect", redirect, 0);
    check("rst_redirect_pc", redirect_pc, 0);
    reset_n = 1;

    // Plain issue from the register file
    issue(mk_ctrl(1, 0, 0, 0), 5'd7, 5'd1, 5'd2, 32'h100, 32'h200);
    id_pc = 32'h40; id_imm = 32'h7;
    step();
    check("base_valid", ex_valid, 1);
    check("base_s1", ex_s1, 32'h100);
    check("base_s2", ex_s2, 32'h200);
    check("base_rd", ex_rd, 7);
    check("base_pc", ex_pc, 32'h40);
    check("base_imm", ex_imm, 32'h7);
    check("base_ctrl", 64'(ex_ctrl), 64'(mk_ctrl(1, 0, 0, 0)));

    // EX forwarding of r7; this instruction writes r0
    issue(mk_ctrl(1, 0, 0, 0), 5'd0, 5'd7, 5'd1, 32'hDEAD, 32'h321);
    ex_fwd_val = 32'hABC;
    settle();
    check("exfwd_id_ready", id_ready, 1);
    step();
    check("exfwd_s1", ex_s1, 32'hABC);
    check("exfwd_s2", ex_s2, 32'h321);

    // Double forward: MEM wins over WB for r3; WB beats RF for r4
    issue(mk_ctrl(1, 0, 0, 0), 5'd0, 5'd3, 5'd4, 32'h1, 32'h2);
    mem_rd = 3; mem_val = 32'h11; wb_rd = 3; wb_val = 32'h22;
    step();
    check("dfwd_s1", ex_s1, 32'h11);
    wb_rd = 4; wb_val = 32'h33;
    issue(mk_ctrl(1, 0, 0, 0), 5'd0, 5'd3, 5'd4, 32'h1, 32'h2);
    step();
    check("wbfwd_s2", ex_s2, 32'h33);

    // Zero register: EX writes r0 with 0x55
    mem_rd = 0; wb_rd = 0;
    ex_fwd_val = 32'h55;
    issue(mk_ctrl(1, 0, 0, 0), 5'd0, 5'd0, 5'd0, 32'h99, 32'h98);
    step();
    check("r0_s1", ex_s1, 0);
    check("r0_s2", ex_s2, 0);

    // Load-use: lw r5 then add r6,r5,r1
    issue(mk_ctrl(1, 1, 0, 0), 5'd5, 5'd2, 5'd0, 32'h1000, 32'h0);
    step();
    check("lw_in_ex", ex_valid, 1);
    issue(mk_ctrl(1, 0, 0, 0), 5'd6, 5'd5, 5'd1, 32'hBAD, 32'h44);
    settle();
    check("lu_id_ready", id_ready, 0);
    step();
    check("lu_bubble", ex_valid, 0);
    check("lu_bubble_rd", ex_rd, 0);
    check("lu_stall_cnt", stall_cnt, 1);
    mem_rd = 5; mem_is_load = 0; mem_val = 32'h77;
    settle();
    check("lu_id_ready2", id_ready, 1);
    step();
    check("lu_add_valid", ex_valid, 1);
    check("lu_add_s1", ex_s1, 32'h77);
    check("lu_add_s2", ex_s2, 32'h44);
    check("lu_add_rd", ex_rd, 6);
    check("lu_stall_hold", stall_cnt, 1);

    // MEM-stage load hazard on rs2, nullify gating, then counter saturation
    mem_rd = 8; mem_is_load = 1;
    issue(mk_ctrl(1, 0, 0, 0), 5'd9, 5'd0, 5'd8, 32'h0, 32'h0);
    settle();
    check("mld_id_ready", id_ready, 0);
    step();
    check("mld_bubble", ex_valid, 0);
    check("mld_stall_cnt", stall_cnt, 2);
    nullify = 1;
    step();
    check("null_no_count", stall_cnt, 2);
    nullify = 0;
    for (int i = 0; i < 20; i++) step();
    check("stall_sat", stall_cnt, 15);

    // Flush under backpressure
    mem_rd = 0; mem_is_load = 0;
    issue(mk_ctrl(1, 0, 0, 0), 5'd9, 5'd1, 5'd0, 32'h123, 32'h0);
    step();
    check("fl_setup_rd", ex_rd, 9);
    ex_ready = 0;
    issue(mk_ctrl(1, 0, 0, 0), 5'd10, 5'd1, 5'd0, 32'h456, 32'h0);
    settle();
    check("bp_id_ready", id_ready, 0);
    nullify = 1;
    settle();
    check("fl_id_ready", id_ready, 1);
    check("fl_redirect", redirect, 0);
    step();
    check("fl_hold_valid", ex_valid, 1);
    check("fl_hold_rd", ex_rd, 9);
    check("fl_hold_s1", ex_s1, 32'h123);
    nullify = 0; id_valid = 0; ex_ready = 1;
    step();
    check("fl_dropped", ex_valid, 0);
    check("fl_dropped_rd", ex_rd, 0);

    // Jump redirect with wrap-around, hazard block, register target, nullify block
    issue(mk_ctrl(0, 0, 1, 1), 5'd0, 5'd0, 5'd0, 32'h0, 32'h0);
    id_pc = 32'hFFFF_FFFC; id_imm = 32'h8;
    settle();
    check("jmp_redirect", redirect, 1);
    check("jmp_pc", redirect_pc, 32'h4);
    id_rs1 = 5; mem_rd = 5; mem_is_load = 1;
    settle();
    check("jmp_hz_redirect", redirect, 0);
    mem_rd = 0; mem_is_load = 0;
    id_ctrl = mk_ctrl(0, 0, 1, 0); id_rs1 = 3; wb_rd = 3; wb_val = 32'h1000;
    settle();
    check("jr_redirect", redirect, 1);
    check("jr_pc", redirect_pc, 32'h1000);
    nullify = 1;
    settle();
    check("jmp_null_redirect", redirect, 0);
    nullify = 0; wb_rd = 0;

    // Reset mid-stream
    issue(mk_ctrl(1, 0, 0, 0), 5'd6, 5'd1, 5'd2, 32'h5A, 32'h5B);
    step();
    check("mid_valid", ex_valid, 1);
    id_valid = 0;
    reset_n = 0;
    step();
    check("mid_rst_valid", ex_valid, 0);
    check("mid_rst_s1", ex_s1, 0);
    check("mid_rst_stall", stall_cnt, 0);
    reset_n = 1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
